rr_arbiter_7seg: RTL and testbench

- Round-robin arbiter that shares one 7-segment display (segments abcdefg plus decimal point) among 8 requesters.
- The arbiter grants the display to one requester at a time and holds the grant until that requester releases it.
- The display shows the granted requester index as a digit 0-7. The decimal point (none) lights when no grant is active.
- Sits between the user input pins (requests) and the segment output pins, replacing a fixed-priority encoder with a fair, stateful grant.

---
 rtl/rr_arbiter_7seg.sv | 168 ++++++++++++++++
 tb/tb_rr_arbiter_7seg.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_7seg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_7seg
//   Round-robin arbiter that shares one 7-segment display among 8 requesters.
//   A grant is held until the owner drops its request. The display shows the
//   owner index as a digit, and the decimal point (none) lights while idle.
//   All outputs are registered, so there is no combinational path from req.
//
// Optional feature (macro GRANT_TIMEOUT_EN):
//   Limits a tenure to MAX_HOLD cycles. A revoked owner is masked out of
//   arbitration until it drops its request, and timeout pulses for one cycle.
//   When the macro is undefined, timeout is tied low and MAX_HOLD is unused.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (1-255)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req[7:0]  level requests, bit i = requester i
//   gnt[7:0]  one-hot grant, zero when idle
//   gnt_idx   index of current owner, 0 when idle
//   segments  gfedcba active-high digit for gnt_idx, 0 when idle
//   none      1 when no grant is active (decimal point)
//   timeout   one-cycle pulse when the hold limit revokes a grant
// -----------------------------------------------------------------------------
module rr_arbiter_7seg #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic [6:0] segments,
  output logic       none,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE,
    S_GRANTED
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic [6:0] r_segments;
  logic       r_none;

  logic [7:0] w_mask;
  logic [7:0] w_avail;
  logic       w_found;
  logic [2:0] w_winner;

  function automatic logic [6:0] digit(input logic [2:0] d);
    case (d)
      3'd0:    digit = 7'b0111111;
      3'd1:    digit = 7'b0000110;
      3'd2:    digit = 7'b1011011;
      3'd3:    digit = 7'b1001111;
      3'd4:    digit = 7'b1100110;
      3'd5:    digit = 7'b1101101;
      3'd6:    digit = 7'b1111101;
      default: digit = 7'b0000111;
    endcase
  endfunction

`ifdef GRANT_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic [7:0] r_mask;
  logic       r_timeout;

  assign w_mask  = r_mask;
  assign timeout = r_timeout;
`else
  logic [7:0] w_unused_max_hold;

  assign w_unused_max_hold = 8'(MAX_HOLD);
  assign w_mask            = 8'h00;
  assign timeout           = 1'b0;
`endif

  // Search ptr, ptr+1, ... with 3-bit wrap. Walking the offsets from the far
  // end down to 0 lets the nearest available requester overwrite the rest.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_avail  = req & ~w_mask;
    w_found  = 1'b0;
    w_winner = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_avail[r_ptr + 3'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 3'(k);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'd0;
      r_gnt      <= 8'h00;
      r_gnt_idx  <= 3'd0;
      r_segments <= 7'd0;
      r_none     <= 1'b1;
`ifdef GRANT_TIMEOUT_EN
      r_hold_cnt <= 8'd0;
      r_mask     <= 8'h00;
      r_timeout  <= 1'b0;
`endif
    end else begin
`ifdef GRANT_TIMEOUT_EN
      // A masked requester becomes eligible again once it drops req.
      r_timeout <= 1'b0;
      r_mask    <= r_mask & req;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_GRANTED;
            r_gnt      <= 8'b1 << w_winner;
            r_gnt_idx  <= w_winner;
            r_segments <= digit(w_winner);
            r_none     <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            r_hold_cnt <= 8'd0;
`endif
          end
        end
        S_GRANTED: begin
          // A release takes precedence over the hold limit on the same edge.
          if (!req[r_gnt_idx]) begin
            r_state    <= S_IDLE;
            r_ptr      <= r_gnt_idx + 3'd1;
            r_gnt      <= 8'h00;
            r_gnt_idx  <= 3'd0;
            r_segments <= 7'd0;
            r_none     <= 1'b1;
          end
`ifdef GRANT_TIMEOUT_EN
          else if (r_hold_cnt == 8'(MAX_HOLD - 1)) begin
            r_state    <= S_IDLE;
            r_ptr      <= r_gnt_idx + 3'd1;
            r_gnt      <= 8'h00;
            r_gnt_idx  <= 3'd0;
            r_segments <= 7'd0;
            r_none     <= 1'b1;
            r_timeout  <= 1'b1;
            r_mask     <= (r_mask & req) | (8'b1 << r_gnt_idx);
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign gnt_idx  = r_gnt_idx;
  assign segments = r_segments;
  assign none     = r_none;

endmodule

// File: tb/tb_rr_arbiter_7seg.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_7seg
//   Self-checking bench for rr_arbiter_7seg. A behavioural reference model
//   predicts the outputs for each edge; the prediction is queued when the
//   stimulus is driven and compared one time unit after the edge. Each test
//   also checks key values against fixed constants.
//   Define GRANT_TIMEOUT_EN for both bench and RTL to exercise the hold limit.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_7seg;

  localparam int TB_MAX_HOLD = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [6:0] DIG [8] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111
  };

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic [6:0] seg;
    logic       none;
    logic       to;
  } out_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic [6:0] segments;
  logic       none;
  logic       timeout;

  int total;
  int bad;

  out_t sb_q [$];
  out_t exp_o;
  out_t got_o;

  // Reference model state
  bit       m_granted;
  int       m_owner;
  int       m_ptr;
  int       m_hold;
  bit [7:0] m_mask;
  bit       m_to;

  rr_arbiter_7seg #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .segments (segments),
    .none     (none),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample();
    return '{gnt, gnt_idx, segments, none, timeout};
  endfunction

  // Predict the outputs visible after the next edge, given the inputs there.
  function automatic out_t model_step(input logic r, input logic [7:0] rq);
    out_t     o;
    bit [7:0] set_bit;
    set_bit = 8'h00;
    if (r) begin
      m_granted = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_mask = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_granted) begin
        for (int k = 0; k < 8; k++) begin
          int cand;
          cand = (m_ptr + k) % 8;
          if (!m_granted && rq[cand] && !m_mask[cand]) begin
            m_granted = 1; m_owner = cand; m_hold = 0;
          end
        end
      end else if (!rq[m_owner]) begin
        m_granted = 0; m_ptr = (m_owner + 1) % 8;
      end else if (TIMEOUT_EN && m_hold == TB_MAX_HOLD - 1) begin
        m_granted = 0; m_ptr = (m_owner + 1) % 8; m_to = 1;
        set_bit[m_owner] = 1'b1;
      end else begin
        m_hold++;
      end
      if (TIMEOUT_EN) m_mask = (m_mask & rq) | set_bit;
    end
    o.gnt  = m_granted ? (8'b1 << m_owner) : 8'h00;
    o.idx  = m_granted ? 3'(m_owner) : 3'd0;
    o.seg  = m_granted ? DIG[m_owner] : 7'd0;
    o.none = !m_granted;
    o.to   = m_to;
    return o;
  endfunction

  task automatic tick(input logic r, input logic [7:0] rq);
    rst = r;
    req = rq;
    sb_q.push_back(model_step(r, rq));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 8'hFF);
      exp_o = sb_q.pop_front(); got_o = sample(); total++;
      if (got_o !== exp_o) begin
        bad++; $display("FAIL reset_sb t=%0t got=%h exp=%h", $time, got_o, exp_o);
      end
      total++;
      if (gnt !== 8'h00 || none !== 1'b1 || segments !== 7'd0) begin
        bad++; $display("FAIL reset_hold gnt=%h none=%b seg=%b exp gnt=00 none=1 seg=0", gnt, none, segments);
      end
    end
    tick(1'b0, 8'hFF);
    exp_o = sb_q.pop_front(); got_o = sample(); total++;
    if (got_o !== exp_o) begin
      bad++; $display("FAIL reset_first_sb got=%h exp=%h", got_o, exp_o);
    end
    total++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || segments !== 7'b0111111 || none !== 1'b0) begin
      bad++; $display("FAIL reset_first gnt=%h idx=%0d seg=%b none=%b exp 01/0/0111111/0", gnt, gnt_idx, segments, none);
    end
  endtask

  task automatic test_rotation();
    for (int k = 0; k < 9; k++) begin
      total++;
      if (gnt_idx !== 3'(k % 8) || none !== 1'b0) begin
        bad++; $display("FAIL rotation_owner got=%0d exp=%0d none=%b", gnt_idx, k % 8, none);
      end
      for (int h = 0; h < 5; h++) begin
        logic [7:0] rq;
        rq = (h == 3) ? (8'hFF & ~(8'b1 << (k % 8))) : 8'hFF;
        tick(1'b0, rq);
        exp_o = sb_q.pop_front(); got_o = sample(); total++;
        if (got_o !== exp_o) begin
          bad++; $display("FAIL rotation_sb k=%0d h=%0d got=%h exp=%h", k, h, got_o, exp_o);
        end
        if (h == 3) begin
          total++;
          if (none !== 1'b1 || gnt !== 8'h00) begin
            bad++; $display("FAIL rotation_gap none=%b gnt=%h exp none=1 gnt=00", none, gnt);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4];
    seq = '{8'h00, 8'h40, 8'h01, 8'h41};
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, seq[i]);
      exp_o = sb_q.pop_front(); got_o = sample(); total++;
      if (got_o !== exp_o) begin
        bad++; $display("FAIL wrap_sb step=%0d got=%h exp=%h", i, got_o, exp_o);
      end
    end
    total++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01 || segments !== 7'b0111111) begin
      bad++; $display("FAIL wrap_ptr idx=%0d gnt=%h seg=%b exp 0/01/0111111", gnt_idx, gnt, segments);
    end
  endtask

  task automatic test_hold();
    tick(1'b0, 8'h00);
    exp_o = sb_q.pop_front(); got_o = sample(); total++;
    if (got_o !== exp_o) begin
      bad++; $display("FAIL hold_release_sb got=%h exp=%h", got_o, exp_o);
    end
    tick(1'b0, 8'h08);
    exp_o = sb_q.pop_front(); got_o = sample(); total++;
    if (got_o !== exp_o) begin
      bad++; $display("FAIL hold_grant_sb got=%h exp=%h", got_o, exp_o);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 8'hFF);
      exp_o = sb_q.pop_front(); got_o = sample(); total++;
      if (got_o !== exp_o) begin
        bad++; $display("FAIL hold_sb cyc=%0d got=%h exp=%h", i, got_o, exp_o);
      end
      total++;
      if (gnt !== 8'h08 || segments !== 7'b1001111) begin
        bad++; $display("FAIL hold_owner3 cyc=%0d gnt=%h seg=%b exp 08/1001111", i, gnt, segments);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [7:0] rq  [4];
    logic       rr  [4];
    rq = '{8'h00, 8'h20, 8'h20, 8'h30};
    rr = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(rr[i], rq[i]);
      exp_o = sb_q.pop_front(); got_o = sample(); total++;
      if (got_o !== exp_o) begin
        bad++; $display("FAIL rstmid_sb step=%0d got=%h exp=%h", i, got_o, exp_o);
      end
      if (i == 1) begin
        total++;
        if (gnt_idx !== 3'd5) begin
          bad++; $display("FAIL rstmid_owner5 got=%0d exp=5", gnt_idx);
        end
      end
      if (i == 2) begin
        total++;
        if (gnt !== 8'h00 || none !== 1'b1) begin
          bad++; $display("FAIL rstmid_clear gnt=%h none=%b exp 00/1", gnt, none);
        end
      end
    end
    total++;
    if (gnt_idx !== 3'd4 || gnt !== 8'h10) begin
      bad++; $display("FAIL rstmid_ptr0 idx=%0d gnt=%h exp 4/10", gnt_idx, gnt);
    end
  endtask

  // A pulse that rises and falls between two edges must never be granted.
  task automatic test_glitch();
    tick(1'b0, 8'h00);
    exp_o = sb_q.pop_front(); got_o = sample(); total++;
    if (got_o !== exp_o) begin
      bad++; $display("FAIL glitch_release_sb got=%h exp=%h", got_o, exp_o);
    end
    req = 8'h04;
    #3;
    req = 8'h00;
    sb_q.push_back(model_step(1'b0, 8'h00));
    @(posedge clk);
    #1;
    exp_o = sb_q.pop_front(); got_o = sample(); total++;
    if (got_o !== exp_o) begin
      bad++; $display("FAIL glitch_sb got=%h exp=%h", got_o, exp_o);
    end
    total++;
    if (none !== 1'b1 || gnt !== 8'h00) begin
      bad++; $display("FAIL glitch_unseen none=%b gnt=%h exp 1/00", none, gnt);
    end
  endtask

  task automatic test_timeout();
    // Cycle-by-cycle constants for req=03 held with MAX_HOLD=4.
    logic [7:0] exp_gnt [17];
    logic       exp_to  [17];
    logic [7:0] rq;
    exp_gnt = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    exp_to  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 17; i++) begin
      rq = (i == 14) ? 8'h02 : 8'h03;
      tick(i == 0, rq);
      exp_o = sb_q.pop_front(); got_o = sample(); total++;
      if (got_o !== exp_o) begin
        bad++; $display("FAIL timeout_sb cyc=%0d got=%h exp=%h", i, got_o, exp_o);
      end
      total++;
      if (gnt !== exp_gnt[i] || timeout !== exp_to[i]) begin
        bad++; $display("FAIL timeout_seq cyc=%0d gnt=%h to=%b exp %h/%b", i, gnt, timeout, exp_gnt[i], exp_to[i]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 8'h00;
    test_reset();
    test_rotation();
    test_wrap();
`ifndef GRANT_TIMEOUT_EN
    test_hold();
`endif
    test_reset_mid_grant();
    test_glitch();
`ifdef GRANT_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
